// File: rtl/dm_arbiter_pkg.sv
// ------------------------------------------------------------------
// dm_arbiter_pkg: shared encodings for the data-memory arbiter. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package dm_arbiter_pkg;

  // Load/store width codes, identical to the data memory's encoding.
  typedef enum logic [1:0] {
    LS_NONE = 2'b00,
    LS_WORD = 2'b01,
    LS_HALF = 2'b10,
    LS_BYTE = 2'b11
  } ls_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CPU_ACC = 2'b01,
    ST_DMA_ACC = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dm_arb_dma_seq.sv
// ------------------------------------------------------------------
// dm_arb_dma_seq: DMA burst beat/slice counters and address generator. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dm_arb_dma_seq
  import dm_arbiter_pkg::*;
#(
  parameter int SLICE_BEATS = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [4:0]        dma_len_i,
  input  logic              beat_i,
  input  logic              burst_end_i,
  input  logic              slice_end_i,
  output logic              last_o,
  output logic              slice_done_o,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic [ADDR_W-1:0] next_addr_o
);

  localparam int SLICE_W = $clog2(SLICE_BEATS) + 1;

  logic [4:0]         beat_cnt_q, beat_cnt_d;
  logic [SLICE_W-1:0] slice_cnt_q, slice_cnt_d;
  logic [4:0]         len_eff;

  assign len_eff      = (dma_len_i == 5'd0) ? 5'd1 : dma_len_i;
  assign last_o       = (beat_cnt_q + 5'd1) == len_eff;
  assign slice_done_o = (slice_cnt_q + SLICE_W'(1)) == SLICE_W'(SLICE_BEATS);

  assign cur_addr_o  = dma_addr_i + ADDR_W'({beat_cnt_q, 2'b00});
  assign next_addr_o = dma_addr_i + ADDR_W'({beat_cnt_q + 5'd1, 2'b00});

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    slice_cnt_d = slice_cnt_q;
    if (burst_end_i) begin
      beat_cnt_d  = '0;
      slice_cnt_d = '0;
    end else if (beat_i) begin
      beat_cnt_d = beat_cnt_q + 5'd1;
      // An exhausted slice holds its count so the CPU can preempt on any later beat.
      if (slice_end_i) begin
        slice_cnt_d = '0;
      end else if (!slice_done_o) begin
        slice_cnt_d = slice_cnt_q + SLICE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q  <= '0;
      slice_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      slice_cnt_q <= slice_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// ------------------------------------------------------------------
// dm_arbiter: CPU/DMA arbiter for the single-port data memory. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int SLICE_BEATS  = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [1:0]        cpu_ls_i,
  input  logic              cpu_ext_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [4:0]        dma_len_i,
  input  logic [31:0]       dma_wdata_i,
  output logic [31:0]       dma_rdata_o,
  output logic              dma_beat_o,
  output logic              dma_done_o,
  output logic [1:0]        dm_ls_o,
  output logic              dm_we_o,
  output logic              dm_ext_o,
  output logic [31:0]       dm_addr_o,
  output logic [31:0]       dm_wdata_o,
  input  logic [31:0]       dm_rdata_i
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  state_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [1:0]          dm_ls_q, dm_ls_d;
  logic                dm_we_q, dm_we_d;
  logic                dm_ext_q, dm_ext_d;
  logic [31:0]         dm_addr_q, dm_addr_d;
  logic [31:0]         dm_wdata_q, dm_wdata_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d;
  logic [31:0]         dma_rdata_q, dma_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_beat_q, dma_beat_d;
  logic                dma_done_q, dma_done_d;

  logic                seq_beat, seq_burst_end, seq_slice_end;
  logic                seq_last, seq_slice_done;
  logic [ADDR_W-1:0]   seq_cur_addr, seq_next_addr;
  logic                dma_starved;

  dm_arb_dma_seq #(
    .SLICE_BEATS (SLICE_BEATS),
    .ADDR_W      (ADDR_W)
  ) u_dma_seq (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .dma_addr_i   (dma_addr_i),
    .dma_len_i    (dma_len_i),
    .beat_i       (seq_beat),
    .burst_end_i  (seq_burst_end),
    .slice_end_i  (seq_slice_end),
    .last_o       (seq_last),
    .slice_done_o (seq_slice_done),
    .cur_addr_o   (seq_cur_addr),
    .next_addr_o  (seq_next_addr)
  );

  assign dma_starved = dma_req_i && (starve_q == STARVE_W'(STARVE_LIMIT));

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    dm_ls_d       = LS_NONE;
    dm_we_d       = 1'b0;
    dm_ext_d      = 1'b0;
    dm_addr_d     = dm_addr_q;
    dm_wdata_d    = dm_wdata_q;
    cpu_rdata_d   = cpu_rdata_q;
    dma_rdata_d   = dma_rdata_q;
    cpu_ack_d     = 1'b0;
    dma_beat_d    = 1'b0;
    dma_done_d    = 1'b0;
    seq_beat      = 1'b0;
    seq_burst_end = 1'b0;
    seq_slice_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i && !dma_starved) begin
          state_d    = ST_CPU_ACC;
          dm_ls_d    = cpu_ls_i;
          dm_we_d    = cpu_we_i && (cpu_ls_i != LS_NONE);
          dm_ext_d   = cpu_ext_i;
          dm_addr_d  = 32'(cpu_addr_i);
          dm_wdata_d = cpu_wdata_i;
        end else if (dma_req_i) begin
          state_d    = ST_DMA_ACC;
          dm_ls_d    = LS_WORD;
          dm_we_d    = dma_we_i;
          dm_addr_d  = 32'(seq_cur_addr);
          dm_wdata_d = dma_wdata_i;
        end
      end
      ST_CPU_ACC: begin
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = (dm_ls_q == LS_NONE) ? 32'h0 : dm_rdata_i;
        if (!dma_req_i) begin
          starve_d = '0;
        end else if (!dma_starved) begin
          starve_d = starve_q + STARVE_W'(1);
        end
        state_d = ST_IDLE;
      end
      ST_DMA_ACC: begin
        dma_beat_d = 1'b1;
        seq_beat   = 1'b1;
        if (!dm_we_q) begin
          dma_rdata_d = dm_rdata_i;
        end
        if (!dma_req_i || seq_last) begin
          // A withdrawn request ends the burst silently; a natural end signals done.
          dma_done_d    = dma_req_i;
          seq_burst_end = 1'b1;
          starve_d      = '0;
          state_d       = ST_IDLE;
        end else if (seq_slice_done && cpu_req_i) begin
          seq_slice_end = 1'b1;
          starve_d      = '0;
          state_d       = ST_IDLE;
        end else begin
          dm_ls_d    = LS_WORD;
          dm_we_d    = dma_we_i;
          dm_addr_d  = 32'(seq_next_addr);
          dm_wdata_d = dma_wdata_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      dm_ls_q     <= LS_NONE;
      dm_we_q     <= 1'b0;
      dm_ext_q    <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_beat_q  <= 1'b0;
      dma_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      dm_ls_q     <= dm_ls_d;
      dm_we_q     <= dm_we_d;
      dm_ext_q    <= dm_ext_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_beat_q  <= dma_beat_d;
      dma_done_q  <= dma_done_d;
    end
  end

  assign cpu_rdata_o = cpu_rdata_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;
  assign dma_rdata_o = dma_rdata_q;
  assign dma_beat_o  = dma_beat_q;
  assign dma_done_o  = dma_done_q;
  assign dm_ls_o     = dm_ls_q;
  assign dm_we_o     = dm_we_q;
  assign dm_ext_o    = dm_ext_q;
  assign dm_addr_o   = dm_addr_q;
  assign dm_wdata_o  = dm_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// ------------------------------------------------------------------
// tb_dm_arbiter: directed self-checking bench for dm_arbiter. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_ext;
  logic [1:0]  cpu_ls;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [4:0]  dma_len;
  logic        dma_beat, dma_done;
  logic [1:0]  dm_ls;
  logic        dm_we, dm_ext;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_arbiter #(
    .STARVE_LIMIT (4),
    .SLICE_BEATS  (4),
    .ADDR_W       (32)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_ls_i    (cpu_ls),
    .cpu_ext_i   (cpu_ext),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_ack_o   (cpu_ack),
    .cpu_stall_o (cpu_stall),
    .dma_req_i   (dma_req),
    .dma_we_i    (dma_we),
    .dma_addr_i  (dma_addr),
    .dma_len_i   (dma_len),
    .dma_wdata_i (dma_wdata),
    .dma_rdata_o (dma_rdata),
    .dma_beat_o  (dma_beat),
    .dma_done_o  (dma_done),
    .dm_ls_o     (dm_ls),
    .dm_we_o     (dm_we),
    .dm_ext_o    (dm_ext),
    .dm_addr_o   (dm_addr),
    .dm_wdata_o  (dm_wdata),
    .dm_rdata_i  (dm_rdata)
  );

  // Little-endian data memory with combinational read and a log of every write.
  logic [31:0] mem [0:255];
  logic        mem_clr;
  logic [31:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  int          n_log = 0;
  logic [31:0] mem_word;
  logic [15:0] rd_h;
  logic [7:0]  rd_b;

  always_comb begin
    mem_word = mem[dm_addr[9:2]];
    rd_h     = dm_addr[1] ? mem_word[31:16] : mem_word[15:0];
    rd_b     = mem_word[{dm_addr[1:0], 3'b000} +: 8];
    dm_rdata = 32'h0;
    case (dm_ls)
      2'b01:   dm_rdata = mem_word;
      2'b10:   dm_rdata = dm_ext ? {{16{rd_h[15]}}, rd_h} : {16'h0, rd_h};
      2'b11:   dm_rdata = dm_ext ? {{24{rd_b[7]}}, rd_b} : {24'h0, rd_b};
      default: dm_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (dm_we && dm_ls != 2'b00) begin
      case (dm_ls)
        2'b01: mem[dm_addr[9:2]] <= dm_wdata;
        2'b10: if (dm_addr[1]) mem[dm_addr[9:2]][31:16] <= dm_wdata[15:0];
               else            mem[dm_addr[9:2]][15:0]  <= dm_wdata[15:0];
        default: mem[dm_addr[9:2]][{dm_addr[1:0], 3'b000} +: 8] <= dm_wdata[7:0];
      endcase
      if (n_log < 64) begin
        log_addr[n_log] <= dm_addr;
        log_data[n_log] <= dm_wdata;
        n_log           <= n_log + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One CPU access: cycle 1 shows the memory controls, cycle 2 the ack, cycle 3 idle.
  task automatic cpu_op(input string tag, input logic we, input logic [1:0] ls, input logic ext,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rd);
    cpu_req = 1'b1; cpu_we = we; cpu_ls = ls; cpu_ext = ext; cpu_addr = addr; cpu_wdata = wdata;
    step;
    check({tag, " c1 ls"},    32'(dm_ls), 32'(ls));
    check({tag, " c1 addr"},  dm_addr, addr);
    check({tag, " c1 we"},    32'(dm_we), (ls == 2'b00) ? 32'h0 : 32'(we));
    check({tag, " c1 ext"},   32'(dm_ext), 32'(ext));
    check({tag, " c1 stall"}, 32'(cpu_stall), 32'h1);
    if (we) check({tag, " c1 wdata"}, dm_wdata, wdata);
    step;
    check({tag, " c2 ack"}, 32'(cpu_ack), 32'h1);
    check({tag, " c2 ls"},  32'(dm_ls), 32'h0);
    if (!we || ls == 2'b00) check({tag, " c2 rdata"}, cpu_rdata, exp_rd);
    cpu_req = 1'b0;
    step;
    check({tag, " c3 ack"}, 32'(cpu_ack), 32'h0);
    check({tag, " c3 ls"},  32'(dm_ls), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, acks, n_done, beat_at_ack, done_beat, start, acks_pre, slice_beats;
    int t1, t2, cyc;
    logic stall_ok, done_with_beat;

    rst_n = 1'b0; mem_clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_ls = 2'b00; cpu_ext = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
    step; step;
    check("rst dm_ls",   32'(dm_ls), 32'h0);
    check("rst dm_we",   32'(dm_we), 32'h0);
    check("rst dm_addr", dm_addr, 32'h0);
    check("rst cpu_ack", 32'(cpu_ack), 32'h0);
    check("rst dma_beat", 32'(dma_beat), 32'h0);
    mem_clr = 1'b0; rst_n = 1'b1;
    step;

    // CPU word store/load, sub-word store and extended loads, NONE access.
    cpu_op("st_w",  1'b1, 2'b01, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0);
    cpu_op("ld_w",  1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF);
    cpu_op("st_h",  1'b1, 2'b10, 1'b0, 32'h22, 32'h00001234, 32'h0);
    cpu_op("ld_bs", 1'b0, 2'b11, 1'b1, 32'h23, 32'h0, 32'h00000012);
    cpu_op("ld_bn", 1'b0, 2'b11, 1'b1, 32'h20, 32'h0, 32'hFFFFFFEF);
    cpu_op("none",  1'b1, 2'b00, 1'b0, 32'h20, 32'hFFFFFFFF, 32'h0);
    cpu_op("ld_w2", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'h1234BEEF);

    // 8-beat DMA write, CPU requests during beat 1 and takes the slot after beat 4.
    start = n_log;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_len = 5'd8; dma_wdata = 32'h11110000;
    step;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_ls = 2'b01; cpu_ext = 1'b0; cpu_addr = 32'h20;
    beats = 0; acks = 0; n_done = 0; beat_at_ack = -1; done_beat = -1;
    for (int c = 0; c < 60 && dma_req; c++) begin
      step;
      if (dma_beat) beats++;
      if (cpu_ack) begin
        acks++; beat_at_ack = beats;
        check("dma8 cpu_rdata", cpu_rdata, 32'h1234BEEF);
        cpu_req = 1'b0;
      end
      if (dma_done) begin n_done++; done_beat = beats; dma_req = 1'b0; end
    end
    dma_req = 1'b0; cpu_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step;
      if (dma_beat) beats++;
      if (dma_done) n_done++;
    end
    check("dma8 beats",       beats, 8);
    check("dma8 beat_at_ack", beat_at_ack, 4);
    check("dma8 done_beat",   done_beat, 8);
    check("dma8 done_count",  n_done, 1);
    check("dma8 cpu_acks",    acks, 1);
    check("dma8 writes",      n_log - start, 8);
    for (int i = 0; i < 8; i++) begin
      if (start + i < 64) begin
        check($sformatf("dma8 addr%0d", i), log_addr[start + i], 32'h40 + 32'(4 * i));
        check($sformatf("dma8 data%0d", i), log_data[start + i], 32'h11110000);
      end
    end

    // CPU held continuously with a DMA read pending: 4 acks, then a 4-beat slice.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_ls = 2'b01; cpu_addr = 32'h20;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40; dma_len = 5'd8;
    beats = 0; acks = 0; acks_pre = 0; slice_beats = -1; t1 = -1; t2 = -1; stall_ok = 1'b1;
    cyc = 0;
    for (int c = 0; c < 100 && dma_req; c++) begin
      step;
      cyc++;
      if (cpu_ack) begin
        acks++;
        if (beats == 0) acks_pre++;
        if (acks == 1) t1 = cyc;
        if (acks == 2) t2 = cyc;
        if (beats > 0 && slice_beats < 0) slice_beats = beats;
      end
      if (dma_beat) begin
        beats++;
        if (beats == 1) check("starve first rdata", dma_rdata, 32'h11110000);
      end
      if (beats > 0 && slice_beats < 0 && !cpu_stall) stall_ok = 1'b0;
      if (dma_done) begin dma_req = 1'b0; cpu_req = 1'b0; end
    end
    dma_req = 1'b0; cpu_req = 1'b0;
    check("starve acks_before_dma", acks_pre, 4);
    check("starve ack_spacing",     t2 - t1, 2);
    check("starve slice_beats",     slice_beats, 4);
    check("starve stall_in_slice",  32'(stall_ok), 32'h1);
    check("starve total_beats",     beats, 8);
    check("starve total_acks",      acks, 8);
    step; step;

    // Zero length: one beat carrying done.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h44; dma_len = 5'd0;
    beats = 0; n_done = 0; done_with_beat = 1'b0;
    for (int c = 0; c < 10 && dma_req; c++) begin
      step;
      if (dma_beat) begin
        beats++;
        done_with_beat = dma_done;
        check("len0 rdata", dma_rdata, 32'h11110000);
      end
      if (dma_done) begin n_done++; dma_req = 1'b0; end
    end
    dma_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step;
      if (dma_beat) beats++;
      if (dma_done) n_done++;
    end
    check("len0 beats",     beats, 1);
    check("len0 done_beat", 32'(done_with_beat), 32'h1);
    check("len0 dones",     n_done, 1);

    // Reset in the middle of a burst, then a fresh 3-beat burst.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_len = 5'd8; dma_wdata = 32'h22220000;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      step;
      if (dma_beat) beats++;
    end
    check("rstmid reached_beat2", beats, 2);
    rst_n = 1'b0;
    #1;
    check("rstmid dm_ls",     32'(dm_ls), 32'h0);
    check("rstmid dm_we",     32'(dm_we), 32'h0);
    check("rstmid dm_addr",   dm_addr, 32'h0);
    check("rstmid dm_wdata",  dm_wdata, 32'h0);
    check("rstmid dma_beat",  32'(dma_beat), 32'h0);
    check("rstmid dma_rdata", dma_rdata, 32'h0);
    check("rstmid cpu_rdata", cpu_rdata, 32'h0);
    dma_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step;
    start = n_log;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_len = 5'd3; dma_wdata = 32'h33330000;
    beats = 0; n_done = 0;
    for (int c = 0; c < 20 && dma_req; c++) begin
      step;
      if (dma_beat) beats++;
      if (dma_done) begin n_done++; dma_req = 1'b0; end
    end
    dma_req = 1'b0;
    step;
    check("post_rst beats",  beats, 3);
    check("post_rst done",   n_done, 1);
    check("post_rst writes", n_log - start, 3);
    for (int i = 0; i < 3; i++) begin
      if (start + i < 64)
        check($sformatf("post_rst addr%0d", i), log_addr[start + i], 32'h100 + 32'(4 * i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
